muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// 32-step shift-add multiply and restoring divide on magnitudes, then a sign-fix cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    typedef enum logic [2:0] {
        OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
        OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_RSVD = 3'd7
    } op_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opb;
    logic        is_div;
    logic        neg_lo;
    logic        neg_hi;

    logic        accept;
    logic        op_md;
    logic        op_signed;
    logic        op_isdiv;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;

    assign accept    = start && !cancel && (state == IDLE);
    assign op_md     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_isdiv  = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg     = op_signed && din1[31];
    assign b_neg     = op_signed && din2[31];
    assign mag_a     = a_neg ? -din1 : din1;
    assign mag_b     = b_neg ? -din2 : din2;

    // acc = {partial product, remaining multiplier bits} for multiply,
    // acc = {partial remainder, dividend/quotient shift} for divide.
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_next  = {mul_sum, acc[31:1]};
    assign div_shift = {acc[63:32], acc[31]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0],  acc[30:0], 1'b1};
    assign prod_fix  = neg_lo ? -acc : acc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && op_md) state_nx = CALC;
            CALC: begin
                if (cancel)            state_nx = IDLE;
                else if (cnt == 5'd31) state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= (state == FIX) && !cancel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && op_md) begin
                        cnt    <= '0;
                        is_div <= op_isdiv;
                        neg_hi <= a_neg;
                        if (op_isdiv) begin
                            acc    <= {32'd0, mag_a};
                            opb    <= mag_b;
                            // Divide by zero keeps an all-ones quotient regardless of signs.
                            neg_lo <= (a_neg ^ b_neg) && (din2 != 32'd0);
                        end else begin
                            acc    <= {32'd0, mag_b};
                            opb    <= mag_a;
                            neg_lo <= a_neg ^ b_neg;
                        end
                    end
                    if (accept && (op == OP_MTHI)) hi <= din1;
                    if (accept && (op == OP_MTLO)) lo <= din1;
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    acc <= is_div ? div_next : mul_next;
                end
                FIX: begin
                    if (!cancel) begin
                        if (is_div) begin
                            lo <= neg_lo ? -acc[31:0]  : acc[31:0];
                            hi <= neg_hi ? -acc[63:32] : acc[63:32];
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
